nl_req_ctrl: RTL and testbench
==============================

// Module: nl_req_ctrl
// PURPOSE
// - RSA-side initiator for the NonLinear init/done interface. Accepts a stage request (predict/newlm/update) plus
//   operands, fires the matching init_* pulse, holds operands stable, waits for the matching done_*, captures
//   result_0..5, then streams the valid results one word per handshake back to the RSA write path.
// - Adds a timeout so a missing done_* never hangs the RSA stage FSM.
// PARAMETERS
// - RSA_DW     32    data width of coordinates/results (signed)
// - RSA_AW     17    angle width (xita, signed)
// - TIMEOUT_W  12    width of WAIT timeout counter
// - TIMEOUT    2047  WAIT cycles before abort; must be < 2**TIMEOUT_W
// PORTS
// - clk          in   1       clock
// - sys_rst      in   1       synchronous active-high reset
// - req_val      in   1       request valid
// - req_rdy      out  1       request ready (1 only in IDLE)
// - req_op       in   2       0=predict 1=newlm 2=update 3=reserved
// - req_xk/req_yk/req_lkx/req_lky  in  RSA_DW each  operands
// - req_xita     in   RSA_AW  robot heading operand
// - init_predict/init_newlm/init_update  out  1 each  one-cycle launch pulses to NonLinear
// - xk/yk/lkx/lky  out  RSA_DW each  registered operands to NonLinear
// - xita         out  RSA_AW  registered heading to NonLinear
// - done_predict/done_newlm/done_update  in  1 each  completion pulses from NonLinear
// - result_0..result_5  in  RSA_DW each  NonLinear results, valid in done cycle
// - res_val      out  1       result word valid
// - res_rdy      in   1       result word accepted
// - res_data     out  RSA_DW  result word
// - res_idx      out  3       index of res_data (0..5)
// - res_last     out  1       final word of this op
// - err_timeout  out  1       one-cycle pulse on timeout abort
// - busy         out  1       state != IDLE
// BEHAVIOUR
// - Reset: state IDLE; every output 0 except req_rdy=1; operand/result regs cleared; counters 0.
// - FSM IDLE->LAUNCH->WAIT->DRAIN->IDLE. Result count N: predict 3, newlm 2, update 6.
// - IDLE: req_rdy=1. On req_val: latch op+operands onto xk..xita. op 0..2 -> LAUNCH; op 3 consumed, no effect, stay IDLE.
// - LAUNCH (1 cycle): assert init_* of latched op only. done_* ignored. -> WAIT, timeout cnt=0.
// - WAIT: on matching done_*, capture result_0..5 (all six) that cycle -> DRAIN, word ptr=0.
//   Non-matching done_* ignored. Timeout cnt +1 per cycle; cnt==TIMEOUT without done -> err_timeout pulse, -> IDLE, no stream.
// - Matching done in the same cycle cnt reaches TIMEOUT: done wins, no error.
// - DRAIN: res_val=1, res_data=captured[ptr], res_idx=ptr, res_last=(ptr==N-1). Outputs stable while res_rdy=0.
//   On res_val&res_rdy: ptr+1; if last -> IDLE (req_rdy=1 next cycle).
// - xk..xita held from LAUNCH until next accepted request (stable through WAIT and DRAIN).
// - Latency: req accepted cycle T -> init at T+1 -> done earliest T+2 -> res_val first at cycle after done.
// - done_* arriving in IDLE or DRAIN ignored; no result overwrite.
// - sys_rst mid-op (any state): next cycle in reset state; pending NonLinear done afterwards ignored.
// - Arithmetic: none on data; results passed through bit-exact, signedness preserved.
// STRUCTURE
// - Shared package/macro header: op codes, per-op result counts, FSM state encoding, TIMEOUT default.
// - One sub-module: nl_result_buf (6 x RSA_DW capture regs, load on cap_en, read mux by 3-bit idx).
// - FSM, timeout counter, word pointer and operand regs stay in nl_req_ctrl.
// TESTING
// - Predict: op=0, xk=100 yk=-5 xita=300; model done_predict 4 cycles after init with result_0..2=11,22,33,
//   res_rdy=1 -> exactly one init_predict pulse, 3 words idx0..2 = 11,22,33, res_last on 33, then req_rdy=1.
// - Update with backpressure: op=2, results 1..6, res_rdy toggled 1-0-0-1 -> 6 words in order, data held stable
//   while res_rdy=0, res_last only on idx5 value 6.
// - Wrong done: op=1, model pulses done_update then done_newlm (results 7,8) -> done_update ignored; 2 words 7,8.
// - Timeout: op=0, never assert done -> err_timeout pulse exactly TIMEOUT cycles after WAIT entry, no res_val, back to IDLE.
// - Reset mid-DRAIN: sys_rst after word 1 of update -> all outputs 0, req_rdy=1; late done_update ignored.
// - Reserved op=3 -> req accepted, no init_* pulse, busy stays 0.

Source files
------------

// File: rtl/nl_req_ctrl_pkg.sv
// Shared definitions for the NonLinear request controller: op codes, FSM
// state encoding, per-op result counts and timeout defaults.
package nl_req_ctrl_pkg;

  typedef enum logic [1:0] {
    OP_PREDICT = 2'd0,
    OP_NEWLM   = 2'd1,
    OP_UPDATE  = 2'd2,
    OP_RSVD    = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_WAIT   = 2'd2,
    ST_DRAIN  = 2'd3
  } state_e;

  localparam int TIMEOUT_W_DEFAULT = 12;
  localparam int TIMEOUT_DEFAULT   = 2047;

  localparam logic [2:0] N_PREDICT = 3'd3;
  localparam logic [2:0] N_NEWLM   = 3'd2;
  localparam logic [2:0] N_UPDATE  = 3'd6;

  function automatic logic [2:0] result_count(input op_e op);
    case (op)
      OP_PREDICT: return N_PREDICT;
      OP_NEWLM:   return N_NEWLM;
      OP_UPDATE:  return N_UPDATE;
      default:    return 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/nl_req_ctrl_result_buf.sv
// Six-word capture buffer for NonLinear results, loaded in the done cycle
// and read back one word at a time by index.
module nl_result_buf #(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          sys_rst,
  input  logic          cap_en,
  input  logic [DW-1:0] d0,
  input  logic [DW-1:0] d1,
  input  logic [DW-1:0] d2,
  input  logic [DW-1:0] d3,
  input  logic [DW-1:0] d4,
  input  logic [DW-1:0] d5,
  input  logic [2:0]    idx,
  output logic [DW-1:0] rd_data
);

  logic [DW-1:0] regs [6];

  // NOTE: the buffer is reset so stale results from an aborted op never leak out.
  always_ff @(posedge clk) begin
    if (sys_rst) begin
      for (int i = 0; i < 6; i++) regs[i] <= '0;
    end else if (cap_en) begin
      regs[0] <= d0;
      regs[1] <= d1;
      regs[2] <= d2;
      regs[3] <= d3;
      regs[4] <= d4;
      regs[5] <= d5;
    end
  end

  always_comb begin
    case (idx)
      3'd0:    rd_data = regs[0];
      3'd1:    rd_data = regs[1];
      3'd2:    rd_data = regs[2];
      3'd3:    rd_data = regs[3];
      3'd4:    rd_data = regs[4];
      3'd5:    rd_data = regs[5];
      default: rd_data = '0;
    endcase
  end

endmodule

// File: rtl/nl_req_ctrl.sv
// RSA-side initiator for the NonLinear init/done interface: launches one op,
// waits for its done (with timeout), then streams the captured results.
module nl_req_ctrl
  import nl_req_ctrl_pkg::*;
#(
  parameter int RSA_DW    = 32,
  parameter int RSA_AW    = 17,
  parameter int TIMEOUT_W = TIMEOUT_W_DEFAULT,
  parameter int TIMEOUT   = TIMEOUT_DEFAULT
) (
  input  logic              clk,
  input  logic              sys_rst,
  input  logic              req_val,
  output logic              req_rdy,
  input  logic [1:0]        req_op,
  input  logic [RSA_DW-1:0] req_xk,
  input  logic [RSA_DW-1:0] req_yk,
  input  logic [RSA_DW-1:0] req_lkx,
  input  logic [RSA_DW-1:0] req_lky,
  input  logic [RSA_AW-1:0] req_xita,
  output logic              init_predict,
  output logic              init_newlm,
  output logic              init_update,
  output logic [RSA_DW-1:0] xk,
  output logic [RSA_DW-1:0] yk,
  output logic [RSA_DW-1:0] lkx,
  output logic [RSA_DW-1:0] lky,
  output logic [RSA_AW-1:0] xita,
  input  logic              done_predict,
  input  logic              done_newlm,
  input  logic              done_update,
  input  logic [RSA_DW-1:0] result_0,
  input  logic [RSA_DW-1:0] result_1,
  input  logic [RSA_DW-1:0] result_2,
  input  logic [RSA_DW-1:0] result_3,
  input  logic [RSA_DW-1:0] result_4,
  input  logic [RSA_DW-1:0] result_5,
  output logic              res_val,
  input  logic              res_rdy,
  output logic [RSA_DW-1:0] res_data,
  output logic [2:0]        res_idx,
  output logic              res_last,
  output logic              err_timeout,
  output logic              busy
);

  state_e                state;
  op_e                   op_q;
  logic [TIMEOUT_W-1:0]  cnt;
  logic [2:0]            ptr;
  logic                  done_match;
  logic                  last_word;
  logic                  cap_en;
  logic [RSA_DW-1:0]     buf_data;

  // NOTE: every variable gets a default before the case so no latch is inferred.
  always_comb begin
    done_match = 1'b0;
    case (op_q)
      OP_PREDICT: done_match = done_predict;
      OP_NEWLM:   done_match = done_newlm;
      OP_UPDATE:  done_match = done_update;
      default:    done_match = 1'b0;
    endcase
  end

  assign last_word = (ptr == result_count(op_q) - 3'd1);
  assign cap_en    = (state == ST_WAIT) && done_match;

  // A done arriving in the very cycle the count hits TIMEOUT still wins.
  assign err_timeout = (state == ST_WAIT) && !done_match &&
                       (cnt == TIMEOUT_W'(TIMEOUT));

  assign req_rdy  = (state == ST_IDLE);
  assign busy     = (state != ST_IDLE);
  assign res_val  = (state == ST_DRAIN);
  assign res_idx  = ptr;
  assign res_last = res_val && last_word;
  assign res_data = res_val ? buf_data : '0;

  nl_result_buf #(.DW(RSA_DW)) u_result_buf (
    .clk     (clk),
    .sys_rst (sys_rst),
    .cap_en  (cap_en),
    .d0      (result_0),
    .d1      (result_1),
    .d2      (result_2),
    .d3      (result_3),
    .d4      (result_4),
    .d5      (result_5),
    .idx     (ptr),
    .rd_data (buf_data)
  );

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (sys_rst) begin
      state        <= ST_IDLE;
      op_q         <= OP_PREDICT;
      cnt          <= '0;
      ptr          <= '0;
      init_predict <= 1'b0;
      init_newlm   <= 1'b0;
      init_update  <= 1'b0;
      xk           <= '0;
      yk           <= '0;
      lkx          <= '0;
      lky          <= '0;
      xita         <= '0;
    end else begin
      init_predict <= 1'b0;
      init_newlm   <= 1'b0;
      init_update  <= 1'b0;
      case (state)
        ST_IDLE: begin
          // Reserved op is consumed without touching the operand registers.
          if (req_val && (op_e'(req_op) != OP_RSVD)) begin
            op_q         <= op_e'(req_op);
            xk           <= req_xk;
            yk           <= req_yk;
            lkx          <= req_lkx;
            lky          <= req_lky;
            xita         <= req_xita;
            init_predict <= (op_e'(req_op) == OP_PREDICT);
            init_newlm   <= (op_e'(req_op) == OP_NEWLM);
            init_update  <= (op_e'(req_op) == OP_UPDATE);
            state        <= ST_LAUNCH;
          end
        end
        ST_LAUNCH: begin
          cnt   <= '0;
          state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (done_match) begin
            ptr   <= '0;
            state <= ST_DRAIN;
          end else if (err_timeout) begin
            state <= ST_IDLE;
          end else begin
            cnt <= cnt + TIMEOUT_W'(1);
          end
        end
        ST_DRAIN: begin
          if (res_rdy) begin
            if (last_word) begin
              ptr   <= '0;
              state <= ST_IDLE;
            end else begin
              ptr <= ptr + 3'd1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nl_req_ctrl.sv
// Self-checking bench for nl_req_ctrl: table of op vectors with a result
// scoreboard, plus hand sequences for timeout and reset during DRAIN.
module tb_nl_req_ctrl;

  localparam int DW = 32;
  localparam int AW = 17;
  localparam int TO = 2047;

  typedef struct packed {
    logic [1:0]         op;
    logic [31:0]        xk;
    logic [31:0]        yk;
    logic [31:0]        lkx;
    logic [31:0]        lky;
    logic [16:0]        xita;
    logic [5:0][31:0]   r;
    logic [31:0]        delay;
    logic               decoy;
    logic               bp;
    logic [2:0]         exp_n;
    logic [2:0]         exp_init;
  } vec_t;

  typedef struct packed {
    logic [2:0]  idx;
    logic        last;
    logic [31:0] data;
  } word_t;

  logic clk;
  logic sys_rst;
  logic req_val;
  logic req_rdy;
  logic [1:0] req_op;
  logic [DW-1:0] req_xk, req_yk, req_lkx, req_lky;
  logic [AW-1:0] req_xita;
  logic init_predict, init_newlm, init_update;
  logic [DW-1:0] xk, yk, lkx, lky;
  logic [AW-1:0] xita;
  logic done_predict, done_newlm, done_update;
  logic [5:0][DW-1:0] res_in;
  logic res_val;
  logic res_rdy = 1'b1;
  logic [DW-1:0] res_data;
  logic [2:0] res_idx;
  logic res_last;
  logic err_timeout;
  logic busy;

  int n_vec = 0;
  int n_fail = 0;
  int cyc = 0;
  int n_init_p = 0, n_init_n = 0, n_init_u = 0;
  int n_err = 0, err_cyc = -1, n_acc = 0;
  int rdy_mode = 0, ph = 0;
  logic [3:0] pat = 4'b1001;
  logic stall_q = 1'b0;
  logic [36:0] stall_word = '0;
  word_t sb[$];
  vec_t vt[6];

  nl_req_ctrl #(.RSA_DW(DW), .RSA_AW(AW), .TIMEOUT_W(12), .TIMEOUT(TO)) dut (
    .clk(clk), .sys_rst(sys_rst),
    .req_val(req_val), .req_rdy(req_rdy), .req_op(req_op),
    .req_xk(req_xk), .req_yk(req_yk), .req_lkx(req_lkx), .req_lky(req_lky),
    .req_xita(req_xita),
    .init_predict(init_predict), .init_newlm(init_newlm), .init_update(init_update),
    .xk(xk), .yk(yk), .lkx(lkx), .lky(lky), .xita(xita),
    .done_predict(done_predict), .done_newlm(done_newlm), .done_update(done_update),
    .result_0(res_in[0]), .result_1(res_in[1]), .result_2(res_in[2]),
    .result_3(res_in[3]), .result_4(res_in[4]), .result_5(res_in[5]),
    .res_val(res_val), .res_rdy(res_rdy), .res_data(res_data), .res_idx(res_idx),
    .res_last(res_last), .err_timeout(err_timeout), .busy(busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Samples the current cycle mid-period, then moves to just after the next edge.
  task automatic monitor();
    word_t e;
    n_init_p += int'(init_predict);
    n_init_n += int'(init_newlm);
    n_init_u += int'(init_update);
    if (err_timeout) begin
      n_err++;
      err_cyc = cyc;
    end
    if (stall_q) check("hold_stable", {res_val, res_idx, res_last, res_data}, stall_word);
    stall_q    = res_val && !res_rdy;
    stall_word = {res_val, res_idx, res_last, res_data};
    if (res_val && res_rdy) begin
      n_acc++;
      if (sb.size() == 0) begin
        check("spurious_word", res_val, 1'b0);
      end else begin
        e = sb.pop_front();
        check("word", {res_idx, res_last, res_data}, e);
      end
    end
    cyc++;
  endtask

  task automatic tick();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
    res_rdy = (rdy_mode == 0) ? 1'b1 : pat[ph % 4];
    ph++;
  endtask

  task automatic drive_done(input logic [1:0] which, input logic [5:0][31:0] r);
    done_predict = (which == 2'd0);
    done_newlm   = (which == 2'd1);
    done_update  = (which == 2'd2);
    res_in       = r;
  endtask

  task automatic clear_done();
    done_predict = 1'b0;
    done_newlm   = 1'b0;
    done_update  = 1'b0;
    for (int i = 0; i < 6; i++) res_in[i] = 32'hBAD0_0000 | 32'(i);
  endtask

  function automatic logic [5:0][31:0] garbage();
    logic [5:0][31:0] g;
    for (int i = 0; i < 6; i++) g[i] = 32'hEEEE_0000 | 32'(i);
    return g;
  endfunction

  task automatic wait_ready();
    int k = 0;
    while (!req_rdy && k < 100) begin
      tick();
      k++;
    end
    check("req_rdy_wait", req_rdy, 1'b1);
  endtask

  task automatic issue(input logic [1:0] op, input logic [31:0] a, b, c, d, input logic [16:0] h);
    req_val = 1'b1; req_op = op;
    req_xk = a; req_yk = b; req_lkx = c; req_lky = d; req_xita = h;
    tick();
    req_val = 1'b0;
    req_xk = $urandom(); req_yk = $urandom(); req_lkx = $urandom(); req_lky = $urandom();
    req_xita = 17'($urandom());
  endtask

  task automatic run_vec(input vec_t v);
    int p0, n0, u0, e0, k;
    word_t w;
    wait_ready();
    p0 = n_init_p; n0 = n_init_n; u0 = n_init_u; e0 = n_err;
    rdy_mode = int'(v.bp); ph = 0;
    issue(v.op, v.xk, v.yk, v.lkx, v.lky, v.xita);
    if (v.op == 2'd3) begin
      tick();
      tick();
      check("rsvd_idle", {busy, req_rdy, res_val}, 3'b010);
    end else begin
      check("operands_launch", {xk, yk, lkx, lky, xita}, {v.xk, v.yk, v.lkx, v.lky, v.xita});
      if (v.decoy) drive_done(v.op, garbage());
      tick();
      clear_done();
      for (int d = 1; d < int'(v.delay); d++) begin
        if (v.decoy && d == 1) drive_done((v.op == 2'd2) ? 2'd0 : v.op + 2'd1, garbage());
        tick();
        clear_done();
      end
      drive_done(v.op, v.r);
      for (int i = 0; i < int'(v.exp_n); i++) begin
        w.idx = 3'(i); w.last = (i == int'(v.exp_n) - 1); w.data = v.r[i];
        sb.push_back(w);
      end
      tick();
      clear_done();
      check("first_word_latency", {res_val, res_idx}, {1'b1, 3'd0});
      drive_done(v.op, garbage());
      tick();
      clear_done();
      k = 0;
      while (sb.size() > 0 && k < 200) begin
        tick();
        k++;
      end
      check("drain_complete", 32'(sb.size()), 32'd0);
      sb.delete();
      check("idle_after", {req_rdy, busy, res_val}, 3'b100);
      check("operands_held", {xk, yk, lkx, lky, xita}, {v.xk, v.yk, v.lkx, v.lky, v.xita});
    end
    check("init_pulses", {8'(n_init_p - p0), 8'(n_init_n - n0), 8'(n_init_u - u0)},
          {8'(v.exp_init[0]), 8'(v.exp_init[1]), 8'(v.exp_init[2])});
    check("no_timeout", 32'(n_err - e0), 32'd0);
    rdy_mode = 0;
  endtask

  task automatic run_timeout();
    int e0, l_cyc, k;
    wait_ready();
    e0 = n_err;
    issue(2'd0, 32'd1, 32'd2, 32'd3, 32'd4, 17'd5);
    l_cyc = cyc;
    k = 0;
    while (n_err == e0 && k < TO + 20) begin
      tick();
      k++;
    end
    check("timeout_cycle", 32'(err_cyc - l_cyc), 32'(TO + 1));
    check("timeout_idle", {req_rdy, busy, err_timeout, res_val}, 4'b1000);
    tick(); tick(); tick();
    check("timeout_single", 32'(n_err - e0), 32'd1);
  endtask

  task automatic run_reset_mid();
    int a0, p0, n0, u0, k;
    word_t w;
    logic [5:0][31:0] r;
    for (int i = 0; i < 6; i++) r[i] = 32'(41 + i);
    wait_ready();
    issue(2'd2, 32'd9, 32'd8, 32'd7, 32'd6, 17'd5);
    tick();
    drive_done(2'd2, r);
    for (int i = 0; i < 6; i++) begin
      w.idx = 3'(i); w.last = (i == 5); w.data = r[i];
      sb.push_back(w);
    end
    tick();
    clear_done();
    a0 = n_acc;
    k = 0;
    while (n_acc - a0 < 2 && k < 50) begin
      tick();
      k++;
    end
    check("reset_mid_words", 32'(n_acc - a0), 32'd2);
    sys_rst = 1'b1;
    tick();
    sys_rst = 1'b0;
    sb.delete();
    stall_q = 1'b0;
    check("reset_mid_ctrl",
          {init_predict, init_newlm, init_update, res_val, res_last, err_timeout, busy, req_rdy, res_idx},
          {8'b0000_0001, 3'd0});
    check("reset_mid_data", {xk, yk, lkx, lky, xita, res_data}, '0);
    p0 = n_init_p; n0 = n_init_n; u0 = n_init_u;
    drive_done(2'd2, r);
    tick();
    clear_done();
    tick(); tick();
    check("late_done_ignored", {busy, res_val, req_rdy}, 3'b001);
    check("late_done_init", 32'((n_init_p - p0) + (n_init_n - n0) + (n_init_u - u0)), 32'd0);
  endtask

  function automatic vec_t mk(input logic [1:0] op, input logic [31:0] a, b, input logic [16:0] h,
                              input logic [5:0][31:0] r, input int delay, input logic decoy, bp,
                              input logic [2:0] n, input logic [2:0] ini);
    vec_t v;
    v.op = op; v.xk = a; v.yk = b; v.lkx = a ^ 32'h5A5A_0000; v.lky = b + 32'd7; v.xita = h;
    v.r = r; v.delay = 32'(delay); v.decoy = decoy; v.bp = bp; v.exp_n = n; v.exp_init = ini;
    return v;
  endfunction

  initial begin
    logic [5:0][31:0] r;
    sys_rst = 1'b1; req_val = 1'b0; req_op = 2'd0;
    req_xk = '0; req_yk = '0; req_lkx = '0; req_lky = '0; req_xita = '0;
    clear_done();

    r = {32'd66, 32'd55, 32'd44, 32'd33, 32'd22, 32'd11};
    vt[0] = mk(2'd0, 32'd100, -32'sd5, 17'd300, r, 4, 1'b0, 1'b0, 3'd3, 3'b001);
    r = {32'd6, 32'd5, 32'd4, 32'd3, 32'd2, 32'd1};
    vt[1] = mk(2'd2, 32'd12, 32'd34, 17'd56, r, 3, 1'b0, 1'b1, 3'd6, 3'b100);
    r = {32'd0, 32'd0, 32'd0, 32'd0, 32'd8, 32'd7};
    vt[2] = mk(2'd1, 32'd77, 32'd88, 17'h1FFFF, r, 3, 1'b1, 1'b0, 3'd2, 3'b010);
    r = {32'd3, 32'd3, 32'd3, 32'd3, 32'h8000_0000, 32'hFFFF_FFFF};
    vt[3] = mk(2'd1, -32'sd1, 32'h7FFF_FFFF, 17'h10000, r, 1, 1'b0, 1'b0, 3'd2, 3'b010);
    vt[4] = mk(2'd3, 32'd1, 32'd1, 17'd1, r, 1, 1'b0, 1'b0, 3'd0, 3'b000);
    r = {32'd16, 32'd15, 32'd14, 32'd13, 32'd12, 32'd11};
    vt[5] = mk(2'd0, 32'd5, 32'd6, 17'd7, r, TO + 1, 1'b0, 1'b1, 3'd3, 3'b001);

    tick();
    tick();
    sys_rst = 1'b0;
    check("reset_ctrl",
          {init_predict, init_newlm, init_update, res_val, res_last, err_timeout, busy, req_rdy, res_idx},
          {8'b0000_0001, 3'd0});
    check("reset_data", {xk, yk, lkx, lky, xita, res_data}, '0);

    for (int i = 0; i < 6; i++) run_vec(vt[i]);
    run_timeout();
    run_reset_mid();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
